simon_key_sched: RTL and testbench

Round-key generator and buffer for the Simon128/128 iterative core. It sits directly upstream of the core's 64-bit per-round `key` input.
- On load, it expands a 128-bit master key into 68 round keys, one per cycle, and stores them.
- It then streams one key per clock, forward for encryption or reverse for decryption, aligned with the core's round counter.
- The core's start pulse (its rst/load cycle) is shared with this block's `start`.

---
 rtl/simon_pkg.sv | 31 +++
 rtl/simon_ks_step.sv | 25 ++
 rtl/simon_key_sched.sv | 165 ++++++++++++++++
 tb/tb_simon_key_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared constants, FSM encoding and z-sequence helper for the Simon128/128
// round-key scheduler.
//   SIMON_ROUNDS : number of round keys generated and streamed (68)
//   SIMON_WORD   : key-word width (64)
//   SIMON_Z2     : z2 constant sequence, consumed LSB-first
//   SIMON_ZLEN   : period of the z sequence (62)
package simon_pkg;

    localparam int SIMON_ROUNDS = 68;
    localparam int SIMON_WORD   = 64;
    localparam logic [63:0] SIMON_Z2 = 64'h7369f885192c0ef5;
    localparam int SIMON_ZLEN   = 62;

    localparam int SIMON_IDX_W = $clog2(SIMON_ROUNDS);
    localparam logic [SIMON_IDX_W-1:0] SIMON_LAST = SIMON_IDX_W'(SIMON_ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } ks_state_e;

    // z2 bit for expansion step i; i only reaches 65, so a single
    // conditional subtract is enough to wrap modulo the sequence period.
    function automatic logic z2_bit(input logic [SIMON_IDX_W-1:0] i);
        logic [SIMON_IDX_W-1:0] j;
        j = (i >= SIMON_IDX_W'(SIMON_ZLEN)) ? (i - SIMON_IDX_W'(SIMON_ZLEN)) : i;
        return SIMON_Z2[j[5:0]];
    endfunction

endpackage

// File: rtl/simon_ks_step.sv
// One Simon128/128 key-expansion step (purely combinational):
//   k_i2 = ~k_i ^ 3 ^ zbit ^ ROTR(k_i1,3) ^ ROTR(k_i1,4)
// Ports:
//   k_i   : key word k[i]
//   k_i1  : key word k[i+1]
//   zbit  : z2 sequence bit for step i
//   k_i2  : resulting key word k[i+2]
module simon_ks_step
    import simon_pkg::*;
(
    input  logic [SIMON_WORD-1:0] k_i,
    input  logic [SIMON_WORD-1:0] k_i1,
    input  logic                  zbit,
    output logic [SIMON_WORD-1:0] k_i2
);

    logic [SIMON_WORD-1:0] rot3;
    logic [SIMON_WORD-1:0] rot4;

    assign rot3 = {k_i1[2:0], k_i1[SIMON_WORD-1:3]};
    assign rot4 = {k_i1[3:0], k_i1[SIMON_WORD-1:4]};

    assign k_i2 = ~k_i ^ SIMON_WORD'(3) ^ {{(SIMON_WORD-1){1'b0}}, zbit} ^ rot3 ^ rot4;

endmodule

// File: rtl/simon_key_sched.sv
// Round-key generator and buffer for the Simon128/128 iterative core.
// key_load captures a 128-bit master key and expands it into 68 round keys
// (one per cycle); start then streams one key per clock in forward (encrypt)
// or reverse (decrypt) order, aligned with the core's round counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   zeroize    : (only with SIMON_KS_ZEROIZE_EN) wipe buffer and shadows
//   key_load   : capture key_in ([63:0]=k0, [127:64]=k1) and expand
//   key_ready  : all round keys valid in the buffer
//   start      : begin streaming (shared with the core's load pulse)
//   encNdec    : sampled at start; 1 = forward order, 0 = reverse order
//   round_key  : key for the current core round (0 when idle)
//   key_valid  : round_key carries a streamed key
//   rnd_last   : round_key is the final key of the stream
// Optional build macro: SIMON_KS_ZEROIZE_EN adds the zeroize input.
module simon_key_sched
    import simon_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
`ifdef SIMON_KS_ZEROIZE_EN
    input  logic                    zeroize,
`endif
    input  logic                    key_load,
    input  logic [2*SIMON_WORD-1:0] key_in,
    output logic                    key_ready,
    input  logic                    start,
    input  logic                    encNdec,
    output logic [SIMON_WORD-1:0]   round_key,
    output logic                    key_valid,
    output logic                    rnd_last
);

    ks_state_e state_q, state_d;

    // Round-key buffer and expansion shadows: deliberately not reset.
    logic [SIMON_WORD-1:0]  mem_q [SIMON_ROUNDS];
    logic [SIMON_WORD-1:0]  ka_q, kb_q, k_new;

    logic [SIMON_IDX_W-1:0] wptr_q, wptr_d;
    logic [SIMON_IDX_W-1:0] idx_q, idx_d;
    logic [SIMON_IDX_W-1:0] rcnt_q, rcnt_d;
    logic                   streaming_q, streaming_d;
    logic                   dir_q, dir_d;
    logic                   start_ok;
    logic [SIMON_IDX_W-1:0] zidx;

    // Expansion step i writes mem[i+2], so the z index trails wptr by two.
    assign zidx = wptr_q - SIMON_IDX_W'(2);

    simon_ks_step u_step (
        .k_i  (ka_q),
        .k_i1 (kb_q),
        .zbit (z2_bit(zidx)),
        .k_i2 (k_new)
    );

    // key_load wins over a coincident start.
    assign start_ok = start && !key_load && (state_q == ST_READY);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        case (state_q)
            ST_EXPAND: begin
                wptr_d = wptr_q + SIMON_IDX_W'(1);
                if (wptr_q == SIMON_LAST) begin
                    state_d = ST_READY;
                end
            end
            default: ;
        endcase
        if (key_load) begin
            state_d = ST_EXPAND;
            wptr_d  = SIMON_IDX_W'(2);
        end
`ifdef SIMON_KS_ZEROIZE_EN
        if (zeroize) begin
            state_d = ST_EMPTY;
            wptr_d  = '0;
        end
`endif
    end

    always_comb begin
        streaming_d = streaming_q;
        idx_d       = idx_q;
        rcnt_d      = rcnt_q;
        dir_d       = dir_q;
        if (streaming_q) begin
            idx_d  = dir_q ? (idx_q + SIMON_IDX_W'(1)) : (idx_q - SIMON_IDX_W'(1));
            rcnt_d = rcnt_q + SIMON_IDX_W'(1);
            if (rcnt_q == SIMON_LAST) begin
                // Park the pointers in range once the stream is over.
                streaming_d = 1'b0;
                idx_d       = '0;
                rcnt_d      = '0;
            end
        end
        if (start_ok) begin
            streaming_d = 1'b1;
            idx_d       = encNdec ? '0 : SIMON_LAST;
            rcnt_d      = '0;
            dir_d       = encNdec;
        end
        if (key_load) begin
            streaming_d = 1'b0;
            idx_d       = '0;
            rcnt_d      = '0;
        end
`ifdef SIMON_KS_ZEROIZE_EN
        if (zeroize) begin
            streaming_d = 1'b0;
            idx_d       = '0;
            rcnt_d      = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            wptr_q      <= '0;
            idx_q       <= '0;
            rcnt_q      <= '0;
            streaming_q <= 1'b0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            idx_q       <= idx_d;
            rcnt_q      <= rcnt_d;
            streaming_q <= streaming_d;
            dir_q       <= dir_d;
        end
    end

    always_ff @(posedge clk) begin
`ifdef SIMON_KS_ZEROIZE_EN
        if (zeroize) begin
            for (int i = 0; i < SIMON_ROUNDS; i++) begin
                mem_q[i] <= '0;
            end
            ka_q <= '0;
            kb_q <= '0;
        end else
`endif
        if (key_load) begin
            mem_q[0] <= key_in[SIMON_WORD-1:0];
            mem_q[1] <= key_in[2*SIMON_WORD-1:SIMON_WORD];
            ka_q     <= key_in[SIMON_WORD-1:0];
            kb_q     <= key_in[2*SIMON_WORD-1:SIMON_WORD];
        end else if (state_q == ST_EXPAND && !rst) begin
            mem_q[wptr_q] <= k_new;
            ka_q          <= kb_q;
            kb_q          <= k_new;
        end
    end

    assign key_ready = (state_q == ST_READY);
    assign key_valid = streaming_q;
    assign rnd_last  = streaming_q && (rcnt_q == SIMON_LAST);
    assign round_key = streaming_q ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_simon_key_sched.sv
// Self-checking bench for simon_key_sched: a behavioural key-expansion model
// plus a Simon128/128 cipher model that consumes the streamed keys.
module tb_simon_key_sched;

    typedef logic [63:0] ks_t [68];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_load = 1'b0;
    logic [127:0]  key_in = '0;
    logic          key_ready;
    logic          start = 1'b0;
    logic          encNdec = 1'b0;
    logic [63:0]   round_key;
    logic          key_valid;
    logic          rnd_last;
`ifdef SIMON_KS_ZEROIZE_EN
    logic          zeroize = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    ks_t model;

    simon_key_sched dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SIMON_KS_ZEROIZE_EN
        .zeroize   (zeroize),
`endif
        .key_load  (key_load),
        .key_in    (key_in),
        .key_ready (key_ready),
        .start     (start),
        .encNdec   (encNdec),
        .round_key (round_key),
        .key_valid (key_valid),
        .rnd_last  (rnd_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] rol(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic ks_t expand(input logic [127:0] k);
        ks_t r;
        logic [63:0] z;
        z = 64'h7369f885192c0ef5;
        r[0] = k[63:0];
        r[1] = k[127:64];
        for (int i = 0; i < 66; i++) begin
            r[i+2] = ~r[i] ^ 64'd3 ^ {63'd0, z[i % 62]} ^ ror(r[i+1], 3) ^ ror(r[i+1], 4);
        end
        return r;
    endfunction

    function automatic logic [63:0] sf(input logic [63:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    // Check one streaming cycle: stream position n, direction enc.
    task automatic chk_cycle(input int n, input bit enc);
        chk($sformatf("valid%0d", n), {127'd0, key_valid}, 128'd1);
        chk($sformatf("key%0d", n), {64'd0, round_key}, {64'd0, model[enc ? n : 67 - n]});
        chk($sformatf("last%0d", n), {127'd0, rnd_last}, {127'd0, (n == 67)});
    endtask

    // Load a key, optionally with a coincident start, optionally pulsing
    // start at expansion cycle start_at; then measure key_ready latency.
    task automatic load_key(input logic [127:0] k, input bit with_start, input int start_at);
        int lat;
        key_in   = k;
        key_load = 1'b1;
        start    = with_start;
        encNdec  = 1'($urandom);
        tick();
        key_load = 1'b0;
        start    = 1'b0;
        chk("load_valid", {127'd0, key_valid}, 128'd0);
        chk("load_ready", {127'd0, key_ready}, 128'd0);
        model = expand(k);
        lat = 0;
        while (!key_ready && lat < 200) begin
            if (lat == start_at) start = 1'b1;
            tick();
            lat++;
            if (start) begin
                start = 1'b0;
                chk("exp_start_valid", {127'd0, key_valid}, 128'd0);
            end
        end
        chk("ready_lat", 128'(lat), 128'd66);
        $display("load key=%h ready after %0d cycles", k, lat);
    endtask

    // Full stream driving the cipher model; returns the resulting block.
    task automatic cipher_stream(input bit enc, input logic [127:0] blk, output logic [127:0] res);
        logic [63:0] x, y, t;
        x = blk[127:64];
        y = blk[63:0];
        start   = 1'b1;
        encNdec = enc;
        tick();
        start = 1'b0;
        for (int n = 0; n < 68; n++) begin
            chk_cycle(n, enc);
            if (enc) begin
                t = x; x = y ^ sf(x) ^ round_key; y = t;
            end else begin
                t = y; y = x ^ sf(y) ^ round_key; x = t;
            end
            encNdec = 1'($urandom);
            tick();
        end
        chk("stream_end", {127'd0, key_valid}, 128'd0);
        res = {x, y};
        $display("stream enc=%0d in=%h out=%h", enc, blk, res);
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] k;
        bit enc, nd;
        int r;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", {127'd0, key_ready}, 128'd0);
        chk("rst_valid", {127'd0, key_valid}, 128'd0);
        chk("rst_key", {64'd0, round_key}, 128'd0);
        chk("rst_last", {127'd0, rnd_last}, 128'd0);
        rst = 1'b0;
        tick();

        // start while EMPTY is ignored
        start = 1'b1; tick(); start = 1'b0;
        chk("empty_start", {127'd0, key_valid}, 128'd0);

        // Known-answer encryption and decryption
        load_key(128'h0f0e0d0c0b0a0908_0706050403020100, 1'b0, 10);
        cipher_stream(1'b1, 128'h63736564207372656c6c657661727420, res);
        chk("ciphertext", res, 128'h49681b1e1e54fe3f65aa832af84e0bbc);
        cipher_stream(1'b0, 128'h49681b1e1e54fe3f65aa832af84e0bbc, res);
        chk("plaintext", res, 128'h63736564207372656c6c657661727420);

        // Randomized: partial stream then restart or key_load abort
        for (int it = 0; it < 6; it++) begin
            enc = 1'($urandom);
            r   = (it == 0) ? 30 : int'($urandom_range(0, 66));
            start = 1'b1; encNdec = enc; tick(); start = 1'b0;
            for (int n = 0; n <= r; n++) begin
                chk_cycle(n, enc);
                if (n < r) begin
                    encNdec = 1'($urandom);
                    tick();
                end
            end
            if (it == 0 || $urandom_range(0, 1) == 0) begin
                k = {$urandom, $urandom, $urandom, $urandom};
                $display("abort stream at round %0d with key_load", r);
                load_key(k, 1'b0, int'($urandom_range(1, 65)));
            end else begin
                nd = 1'($urandom);
                $display("restart stream at round %0d enc=%0d", r, nd);
                start = 1'b1; encNdec = nd; tick(); start = 1'b0;
                for (int n = 0; n < 68; n++) begin
                    chk_cycle(n, nd);
                    encNdec = 1'($urandom);
                    tick();
                end
                chk("restart_end", {127'd0, key_valid}, 128'd0);
            end
        end

        // Simultaneous key_load and start in READY: load wins
        load_key({$urandom, $urandom, $urandom, $urandom}, 1'b1, -1);
        cipher_stream(1'b1, {$urandom, $urandom, $urandom, $urandom}, res);

        // Reset in the middle of expansion
        key_in = {$urandom, $urandom, $urandom, $urandom};
        key_load = 1'b1; tick(); key_load = 1'b0;
        repeat (19) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midexp_rst_ready", {127'd0, key_ready}, 128'd0);
        chk("midexp_rst_valid", {127'd0, key_valid}, 128'd0);
        repeat (70) tick();
        chk("midexp_still_empty", {127'd0, key_ready}, 128'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("midexp_start", {127'd0, key_valid}, 128'd0);
        $display("reset during expansion handled");
        load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, -1);
        cipher_stream(1'b0, {$urandom, $urandom, $urandom, $urandom}, res);

`ifdef SIMON_KS_ZEROIZE_EN
        zeroize = 1'b1; key_load = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        tick();
        zeroize = 1'b0; key_load = 1'b0;
        chk("zero_ready", {127'd0, key_ready}, 128'd0);
        chk("zero_valid", {127'd0, key_valid}, 128'd0);
        repeat (70) tick();
        chk("zero_empty", {127'd0, key_ready}, 128'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("zero_start", {127'd0, key_valid}, 128'd0);
        $display("zeroize with key_load handled");
        load_key(128'd0, 1'b0, -1);
        cipher_stream(1'b1, {$urandom, $urandom, $urandom, $urandom}, res);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
